// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 2-digit 7-segment display among NREQ
// requesters, holding every grant for a minimum dwell so values are readable.
//
// Ports:
//   clock      : system clock, all state on the rising edge
//   reset_n    : asynchronous active-low reset
//   req        : req[i]=1 -> requester i wants the display
//   data_in    : requester i value = data_in[8*i+7:8*i]
//   grant      : one-hot (or zero) current owner
//   owner      : index of the current / last shown requester
//   disp_valid : 1 while disp_data carries a requester value
//   disp_data  : value driven to the display DATA input
module display_arbiter #(
  parameter int          NREQ        = 4,
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [7:0]  BLANK_VAL   = 8'h00
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data_in,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        owner,
  output logic              disp_valid,
  output logic [7:0]        disp_data
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_CYCLES - 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [2:0]        r_owner;
  logic [2:0]        r_last;
  logic              r_valid;
  logic [7:0]        r_data;
  logic [CW-1:0]     r_cnt;

  state_t            w_state_nxt;
  logic [NREQ-1:0]   w_grant_nxt;
  logic [2:0]        w_owner_nxt;
  logic [2:0]        w_last_nxt;
  logic              w_valid_nxt;
  logic [7:0]        w_data_nxt;
  logic [CW-1:0]     w_cnt_nxt;

  logic [2:0]        w_pick;
  logic              w_found;
  logic [NREQ-1:0]   w_pick_oh;
  logic [7:0]        w_pick_data;
  logic [NREQ-1:0]   w_own_oh;
  logic              w_own_req;
  logic [7:0]        w_own_data;
  logic              w_other;
  logic              w_any;
  logic              w_met;
  logic [CW-1:0]     w_cnt_inc;
  logic              w_load;

  // Search starts just after the last owner, so the previous owner
  // is considered last and only wins when nobody else is asking.
  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = 3'(idx);
      end
    end
  end

  assign w_pick_oh   = ONE << w_pick;
  assign w_pick_data = data_in[8*int'(w_pick) +: 8];
  assign w_own_oh    = ONE << r_owner;
  assign w_own_req   = |(req & w_own_oh);
  assign w_own_data  = data_in[8*int'(r_owner) +: 8];
  assign w_other     = |(req & ~w_own_oh);
  assign w_any       = |req;
  assign w_met       = (r_cnt == CMAX);
  assign w_cnt_inc   = w_met ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_any) w_load = 1'b1;
      end
      S_SHOW: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_met) begin
          // Dwell satisfied: hand over directly, no blank gap.
          if (w_other) begin
            w_load = 1'b1;
          end else if (w_own_req) begin
            w_data_nxt = w_own_data;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_data_nxt  = BLANK_VAL;
            w_cnt_nxt   = '0;
          end
        end else if (w_own_req) begin
          w_data_nxt = w_own_data;
        end else begin
          // Owner left early: keep its value on screen, release grant.
          w_state_nxt = S_DWELL;
          w_grant_nxt = '0;
        end
      end
      S_DWELL: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_met) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_data_nxt  = BLANK_VAL;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_data_nxt  = BLANK_VAL;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_load) begin
      w_state_nxt = S_SHOW;
      w_grant_nxt = w_pick_oh;
      w_owner_nxt = w_pick;
      w_last_nxt  = w_pick;
      w_valid_nxt = 1'b1;
      w_data_nxt  = w_pick_data;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= 3'(NREQ - 1);
      r_valid <= 1'b0;
      r_data  <= BLANK_VAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign grant      = r_grant;
  assign owner      = r_owner;
  assign disp_valid = r_valid;
  assign disp_data  = r_data;

endmodule
